gpu_job_scheduler: RTL and testbench
====================================

# gpu_job_scheduler

Job queue and dispatcher that shares a pool of NUM_CU 4x4 matrix-multiply compute units among software-submitted jobs. Each job is a descriptor of three 32-bit addresses (A, B, C); the block buffers descriptors in a FIFO and launches each one on a free compute unit in round-robin order. It tracks completions and raises a sticky interrupt when all work has drained. It sits between the CPU-side register/command path and the array of compute units.

## Interface

Parameters:
- NUM_CU, 4: number of compute units driven; 1..8.
- QUEUE_DEPTH, 8: descriptor FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- job_valid  in  1  descriptor offered.
- job_ready  out  1  FIFO can accept; equals !full.
- job_a_addr, job_b_addr, job_c_addr  in  32 each  descriptor fields.
- enable  in  1  dispatch permitted when high.
- cu_start  out  NUM_CU  one-cycle launch pulse per CU.
- cu_a_addr, cu_b_addr, cu_c_addr  out  NUM_CU*32 each  per-CU operand addresses; CU i uses bits [32i+31:32i].
- cu_busy  in  NUM_CU  CU busy status.
- cu_done  in  NUM_CU  CU one-cycle completion pulse.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy.
- jobs_done  out  32  completed-job counter, wraps modulo 2^32.
- all_idle  out  1  FIFO empty and no CU in flight.
- irq  out  1  sticky drain interrupt.
- irq_clear  in  1  clears irq.

## Operation

- Push: a descriptor is written on an edge where job_valid && job_ready. Writes are not allowed when the FIFO is full, even if a pop occurs in the same cycle. Push and pop in the same cycle are allowed otherwise, and queue_count is unchanged.
- Per-CU in-flight flag, inflight[i]:
  - Set on dispatch to CU i.
  - Cleared on the edge where cu_done[i] is high and inflight[i] is set.
  - cu_done[i] while !inflight[i] is ignored.
- CU i is free when !inflight[i] && !cu_busy[i].
- Dispatch: at most one job per cycle. Dispatch occurs when enable is high, the FIFO is non-empty, and at least one CU is free.
  - Target CU: the first free CU searching from rr_ptr upward, with wrap.
  - On the dispatch edge:
    - Pop the FIFO.
    - Register the descriptor into cu_*_addr[target].
    - Set inflight[target].
    - Drive cu_start[target] high for exactly the next cycle.
    - Set rr_ptr to target+1 mod NUM_CU.
- cu_*_addr[i] holds its value until the next dispatch to CU i.
- A CU whose done is sampled on edge k is first eligible for dispatch on edge k+1.
- enable low: no dispatch. The queue still accepts, in-flight jobs finish, and completions still count.
- jobs_done increments on each edge by the number of valid completions (popcount of cu_done & inflight). Multiple simultaneous completions all count.
- all_idle = (queue_count==0) && (inflight==0). It is combinational from registered state.
- irq:
  - Set on an edge where all_idle rises, i.e. registered previous value 0, current 1.
  - Cleared by irq_clear.
  - Set wins over a simultaneous clear.

## Timing

- Reset (asynchronous assert, synchronous release):
  - FIFO empty; queue_count=0; job_ready=1.
  - inflight=0; rr_ptr=0.
  - cu_start=0; cu_*_addr=0.
  - jobs_done=0; all_idle=1; irq=0; previous-all_idle register=1.
- Reset mid-operation discards queued and in-flight bookkeeping. The CUs are reset by their own reset.
- Latency: descriptor accepted on edge k → the FIFO is non-empty after k → dispatch on edge k+1 → cu_start high in the cycle after edge k+1. There is no FIFO bypass.
- Throughput: one dispatch per cycle while free CUs and queued jobs exist.
- cu_start never asserts for a CU with inflight set, and never on two CUs in the same cycle.
- Full boundary: queue_count==QUEUE_DEPTH → job_ready=0.
- Empty boundary: no dispatch and no pop.
- FIFO pointers wrap modulo QUEUE_DEPTH.

## Test plan

- Reset then single job: push A=0x100, B=0x200, C=0x300 on edge 1 → cu_start[0] pulses after edge 2; cu_a_addr[0]=0x100. Pulse cu_done[0] → jobs_done=1, all_idle rises, irq=1. irq_clear → irq=0.
- Round-robin fill: NUM_CU=4, push 6 jobs back-to-back → starts on CU0, 1, 2, 3 on consecutive cycles; queue_count=2. Done on CU2 → job 5 goes to CU2. Then done on CU0 → job 6 goes to CU0.
- Full FIFO: enable=0, push 8 jobs → job_ready=0 and the 9th job is not accepted, queue_count=8. Set enable=1 → queue_count drops and job_ready returns to 1.
- Simultaneous completions: 4 in flight, cu_done=4'b1111 in one cycle → jobs_done +4 in one edge; irq set.
- Spurious and busy handling: cu_done[3] pulse with no job in flight → jobs_done unchanged. cu_busy[1]=1 externally → CU1 is skipped for dispatch.
- irq priority and reset: all_idle rising coincident with irq_clear → irq=1. Assert rst with 3 jobs queued and 2 in flight → all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/gpu_job_scheduler_if.sv
// Bus bundle between the CPU-side job path, the scheduler and the compute-unit array.
// slave is the scheduler's view; master is the environment (CPU + CUs) view.
interface gpu_job_scheduler_if #(
  parameter int NUM_CU      = 4,
  parameter int QUEUE_DEPTH = 8
);
  logic                             job_valid;
  logic                             job_ready;
  logic [31:0]                      job_a_addr;
  logic [31:0]                      job_b_addr;
  logic [31:0]                      job_c_addr;
  logic                             enable;
  logic [NUM_CU-1:0]                cu_start;
  logic [NUM_CU*32-1:0]             cu_a_addr;
  logic [NUM_CU*32-1:0]             cu_b_addr;
  logic [NUM_CU*32-1:0]             cu_c_addr;
  logic [NUM_CU-1:0]                cu_busy;
  logic [NUM_CU-1:0]                cu_done;
  logic [$clog2(QUEUE_DEPTH):0]     queue_count;
  logic [31:0]                      jobs_done;
  logic                             all_idle;
  logic                             irq;
  logic                             irq_clear;

  modport slave (
    input  job_valid, job_a_addr, job_b_addr, job_c_addr, enable,
           cu_busy, cu_done, irq_clear,
    output job_ready, cu_start, cu_a_addr, cu_b_addr, cu_c_addr,
           queue_count, jobs_done, all_idle, irq
  );

  modport master (
    output job_valid, job_a_addr, job_b_addr, job_c_addr, enable,
           cu_busy, cu_done, irq_clear,
    input  job_ready, cu_start, cu_a_addr, cu_b_addr, cu_c_addr,
           queue_count, jobs_done, all_idle, irq
  );
endinterface

// File: rtl/gpu_job_scheduler.sv
// Descriptor FIFO plus round-robin dispatcher for a pool of matrix-multiply compute units,
// with completion counting and a sticky drain interrupt.
module gpu_job_scheduler #(
  parameter int NUM_CU      = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gpu_job_scheduler_if.slave   bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

  logic [95:0]          mem [QUEUE_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [NUM_CU-1:0]    inflight, free, start_q, target_oh;
  logic [IW-1:0]        rr_ptr, target, idx;
  logic                 found, push, pop, full, all_idle, idle_q, irq_q;
  logic [31:0]          a_q [NUM_CU];
  logic [31:0]          b_q [NUM_CU];
  logic [31:0]          c_q [NUM_CU];
  logic [31:0]          jobs_q;
  logic [3:0]           n_done;
  logic [NUM_CU*32-1:0] flat_a, flat_b, flat_c;

  assign full      = (count == CW'(QUEUE_DEPTH));
  assign push      = bus.job_valid && !full;
  assign free      = ~inflight & ~bus.cu_busy;
  assign pop       = bus.enable && (count != '0) && found;
  assign target_oh = NUM_CU'(1) << target;
  assign all_idle  = (count == '0) && (inflight == '0);

  // First free CU at or after rr_ptr, wrapping around the pool.
  always_comb begin
    found  = 1'b0;
    target = '0;
    idx    = '0;
    for (int k = 0; k < NUM_CU; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_CU);
      if (!found && free[idx]) begin
        found  = 1'b1;
        target = idx;
      end
    end
  end

  always_comb begin
    n_done = '0;
    for (int i = 0; i < NUM_CU; i++)
      n_done = n_done + 4'(bus.cu_done[i] & inflight[i]);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.job_a_addr, bus.job_b_addr, bus.job_c_addr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      rr_ptr   <= '0;
      start_q  <= '0;
      for (int i = 0; i < NUM_CU; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      inflight <= (inflight & ~bus.cu_done) | (pop ? target_oh : '0);
      start_q  <= pop ? target_oh : '0;
      if (pop) begin
        rr_ptr      <= (target == IW'(NUM_CU - 1)) ? '0 : target + 1'b1;
        a_q[target] <= mem[rd_ptr][95:64];
        b_q[target] <= mem[rd_ptr][63:32];
        c_q[target] <= mem[rd_ptr][31:0];
      end
    end
  end

  // irq set on the rising edge of all_idle takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobs_q <= '0;
      idle_q <= 1'b1;
      irq_q  <= 1'b0;
    end else begin
      jobs_q <= jobs_q + 32'(n_done);
      idle_q <= all_idle;
      if (all_idle && !idle_q) irq_q <= 1'b1;
      else if (bus.irq_clear)  irq_q <= 1'b0;
    end
  end

  always_comb begin
    flat_a = '0;
    flat_b = '0;
    flat_c = '0;
    for (int i = 0; i < NUM_CU; i++) begin
      flat_a[32*i +: 32] = a_q[i];
      flat_b[32*i +: 32] = b_q[i];
      flat_c[32*i +: 32] = c_q[i];
    end
  end

  assign bus.job_ready   = !full;
  assign bus.cu_start    = start_q;
  assign bus.cu_a_addr   = flat_a;
  assign bus.cu_b_addr   = flat_b;
  assign bus.cu_c_addr   = flat_c;
  assign bus.queue_count = count;
  assign bus.jobs_done   = jobs_q;
  assign bus.all_idle    = all_idle;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_gpu_job_scheduler.sv
// Directed and randomized bench for gpu_job_scheduler against a queue-based reference model.
module tb_gpu_job_scheduler;
  localparam int NC = 4;
  localparam int QD = 8;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  gpu_job_scheduler_if #(.NUM_CU(NC), .QUEUE_DEPTH(QD)) bus ();
  gpu_job_scheduler #(.NUM_CU(NC), .QUEUE_DEPTH(QD)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: job queue, per-CU busy-with-our-job flags, pointer, counters.
  logic [95:0] mq [$];
  logic [NC-1:0] m_inflight, m_start;
  logic [31:0] m_a [NC];
  logic [31:0] m_b [NC];
  logic [31:0] m_c [NC];
  logic [31:0] m_jobs;
  int          m_rr;
  bit          m_idle_prev, m_irq;

  task automatic model_reset();
    mq.delete();
    m_inflight = '0;
    m_start    = '0;
    m_rr       = 0;
    m_jobs     = '0;
    m_idle_prev = 1'b1;
    m_irq      = 1'b0;
    for (int i = 0; i < NC; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_c[i] = '0;
    end
  endtask

  task automatic model_edge();
    int tgt = -1;
    int nd = 0;
    bit cur_idle, push_ok;
    logic [95:0] d;
    cur_idle = (mq.size() == 0) && (m_inflight == '0);
    push_ok  = bus.job_valid && (mq.size() < QD);
    if (bus.enable && mq.size() > 0)
      for (int k = 0; k < NC; k++) begin
        int i = (m_rr + k) % NC;
        if (tgt < 0 && !m_inflight[i] && !bus.cu_busy[i]) tgt = i;
      end
    for (int i = 0; i < NC; i++) if (bus.cu_done[i] && m_inflight[i]) nd++;
    if (cur_idle && !m_idle_prev) m_irq = 1'b1;
    else if (bus.irq_clear)       m_irq = 1'b0;
    m_idle_prev = cur_idle;
    m_inflight  = m_inflight & ~bus.cu_done;
    m_start     = '0;
    if (tgt >= 0) begin
      d = mq.pop_front();
      m_a[tgt] = d[95:64]; m_b[tgt] = d[63:32]; m_c[tgt] = d[31:0];
      m_inflight[tgt] = 1'b1;
      m_start[tgt]    = 1'b1;
      m_rr = (tgt + 1) % NC;
    end
    if (push_ok) mq.push_back({bus.job_a_addr, bus.job_b_addr, bus.job_c_addr});
    m_jobs = m_jobs + 32'(nd);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NC*32-1:0] ea, eb, ec;
    for (int i = 0; i < NC; i++) begin
      ea[32*i +: 32] = m_a[i]; eb[32*i +: 32] = m_b[i]; ec[32*i +: 32] = m_c[i];
    end
    chk("job_ready",   128'(bus.job_ready),   128'(mq.size() < QD));
    chk("queue_count", 128'(bus.queue_count), 128'(mq.size()));
    chk("cu_start",    128'(bus.cu_start),    128'(m_start));
    chk("cu_a_addr",   128'(bus.cu_a_addr),   128'(ea));
    chk("cu_b_addr",   128'(bus.cu_b_addr),   128'(eb));
    chk("cu_c_addr",   128'(bus.cu_c_addr),   128'(ec));
    chk("jobs_done",   128'(bus.jobs_done),   128'(m_jobs));
    chk("all_idle",    128'(bus.all_idle),    128'((mq.size() == 0) && (m_inflight == '0)));
    chk("irq",         128'(bus.irq),         128'(m_irq));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic set_job(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.job_valid = v; bus.job_a_addr = a; bus.job_b_addr = b; bus.job_c_addr = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_job(1'b0, '0, '0, '0);
    bus.enable = 1'b0; bus.cu_busy = '0; bus.cu_done = '0; bus.irq_clear = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    chk("rst_all_idle",  128'(bus.all_idle),    128'(1));
    chk("rst_job_ready", 128'(bus.job_ready),   128'(1));
    chk("rst_irq",       128'(bus.irq),         128'(0));
    chk("rst_qcount",    128'(bus.queue_count), 128'(0));

    // single job end to end
    bus.enable = 1'b1;
    set_job(1'b1, 32'h100, 32'h200, 32'h300);
    tick();
    bus.job_valid = 1'b0;
    chk("single_qcount", 128'(bus.queue_count), 128'(1));
    tick();
    chk("single_start", 128'(bus.cu_start), 128'(4'b0001));
    chk("single_a0",    128'(bus.cu_a_addr[31:0]), 128'(32'h100));
    chk("single_c0",    128'(bus.cu_c_addr[31:0]), 128'(32'h300));
    tick();
    chk("single_start_off", 128'(bus.cu_start), 128'(0));
    bus.cu_done = 4'b0001;
    tick();
    bus.cu_done = '0;
    chk("single_jobs", 128'(bus.jobs_done), 128'(1));
    chk("single_idle", 128'(bus.all_idle),  128'(1));
    tick();
    chk("single_irq_set", 128'(bus.irq), 128'(1));
    bus.irq_clear = 1'b1;
    tick();
    bus.irq_clear = 1'b0;
    chk("single_irq_clr", 128'(bus.irq), 128'(0));

    // round robin fill
    do_reset();
    bus.enable = 1'b1;
    for (int j = 0; j < 6; j++) begin
      set_job(1'b1, 32'h1000 + j, 32'h2000 + j, 32'h3000 + j);
      tick();
      if (j >= 1 && j <= 4) chk("rr_start", 128'(bus.cu_start), 128'(4'b0001 << (j - 1)));
    end
    bus.job_valid = 1'b0;
    chk("rr_qcount", 128'(bus.queue_count), 128'(2));
    bus.cu_done = 4'b0100; tick(); bus.cu_done = '0; tick();
    chk("rr_cu2_start", 128'(bus.cu_start), 128'(4'b0100));
    chk("rr_cu2_addr",  128'(bus.cu_a_addr[95:64]), 128'(32'h1004));
    bus.cu_done = 4'b0001; tick(); bus.cu_done = '0; tick();
    chk("rr_cu0_start", 128'(bus.cu_start), 128'(4'b0001));
    chk("rr_cu0_addr",  128'(bus.cu_a_addr[31:0]), 128'(32'h1005));
    bus.cu_done = 4'b1111; tick(); bus.cu_done = '0; tick();

    // full fifo, then simultaneous completions
    do_reset();
    bus.enable = 1'b0;
    for (int j = 0; j < 9; j++) begin
      set_job(1'b1, 32'hA000 + j, 32'hB000 + j, 32'hC000 + j);
      tick();
      if (j == 7) chk("full_ready", 128'(bus.job_ready), 128'(0));
    end
    chk("full_qcount", 128'(bus.queue_count), 128'(8));
    bus.job_valid = 1'b0;
    bus.enable = 1'b1;
    tick();
    chk("drain_qcount", 128'(bus.queue_count), 128'(7));
    chk("drain_ready",  128'(bus.job_ready),   128'(1));
    repeat (3) tick();
    bus.cu_done = 4'b1111; tick(); bus.cu_done = '0;
    chk("sim_jobs4", 128'(bus.jobs_done), 128'(4));
    repeat (4) tick();
    bus.cu_done = 4'b1111; tick(); bus.cu_done = '0;
    chk("sim_jobs8", 128'(bus.jobs_done), 128'(8));
    tick();
    chk("sim_irq", 128'(bus.irq), 128'(1));

    // spurious done and busy skip
    bus.irq_clear = 1'b1; tick(); bus.irq_clear = 1'b0;
    bus.cu_done = 4'b1000; tick(); bus.cu_done = '0;
    chk("spurious_jobs", 128'(bus.jobs_done), 128'(8));
    bus.cu_busy = 4'b0010;
    set_job(1'b1, 32'h11, 32'h22, 32'h33); tick();
    set_job(1'b1, 32'h44, 32'h55, 32'h66); tick();
    chk("busy_first", 128'(bus.cu_start), 128'(4'b0001));
    bus.job_valid = 1'b0;
    tick();
    chk("busy_skip", 128'(bus.cu_start), 128'(4'b0100));
    bus.cu_busy = '0;

    // irq set beats a simultaneous clear
    bus.cu_done = 4'b0101; tick(); bus.cu_done = '0;
    bus.irq_clear = 1'b1; tick(); bus.irq_clear = 1'b0;
    chk("irq_priority", 128'(bus.irq), 128'(1));

    // async reset mid-operation: 3 queued, 2 in flight
    bus.cu_busy = 4'b1100;
    for (int j = 0; j < 5; j++) begin
      set_job(1'b1, 32'h500 + j, 32'h600 + j, 32'h700 + j);
      tick();
    end
    bus.job_valid = 1'b0;
    chk("pre_rst_qcount", 128'(bus.queue_count), 128'(3));
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("async_rst_qcount", 128'(bus.queue_count), 128'(0));
    chk("async_rst_idle",   128'(bus.all_idle),    128'(1));
    chk("async_rst_jobs",   128'(bus.jobs_done),   128'(0));
    tick();
    rst = 1'b0;
    bus.cu_busy = '0;

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      logic [NC-1:0] dn, bz;
      for (int i = 0; i < NC; i++) begin
        dn[i] = m_inflight[i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        bz[i] = ($urandom_range(0, 7) == 0);
      end
      set_job($urandom_range(0, 2) != 0, $urandom, $urandom, $urandom);
      bus.enable    = ($urandom_range(0, 7) != 0);
      bus.cu_done   = dn;
      bus.cu_busy   = bz;
      bus.irq_clear = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
